rca_nibble_seq: RTL and testbench

- Sequential multi-precision adder controller that drives an external 4-bit ripple-carry adder stage.
- Accepts two wide operands of 4*NIBBLES bits and feeds them to the adder one nibble per cycle, LSB nibble first.
- Registers the adder's carry-out back into the next nibble's carry-in and assembles the sum nibbles into a full-width result.
- Sits directly around the adder: it produces the adder's inputs and consumes its sum and carry outputs.

---
 rtl/rca_nibble_seq.sv | 115 +++++++++++
 tb/tb_rca_nibble_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_seq.sv
// rtl/rca_nibble_seq.sv - nibble-serial multi-precision add controller around an external 4-bit adder
module rca_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout
);

  localparam int W = 4 * NIBBLES;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] a_sh_q, a_sh_d;
  logic [W-1:0] b_sh_q, b_sh_d;
  logic         carry_q, carry_d;
  logic [3:0]   idx_q, idx_d;
  logic [W-1:0] res_sum_q, res_sum_d;
  logic         res_cout_q, res_cout_d;
  logic         in_run;
  logic         accept;

  always_comb begin
    in_run      = (state_q == S_RUN);
    start_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && res_ready);
    accept      = start_valid && start_ready;
    res_valid   = (state_q == S_DONE);
    add_a       = in_run ? a_sh_q[3:0] : 4'd0;
    add_b       = in_run ? b_sh_q[3:0] : 4'd0;
    add_cin     = in_run ? carry_q : 1'b0;
    res_sum     = res_sum_q;
    res_cout    = res_cout_q;
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;

    case (state_q)
      S_RUN: begin
        // Sum nibbles enter at the top so the LSB nibble ends up at bit 0 after NIBBLES shifts.
        res_sum_d = (res_sum_q >> 4) | (W'(add_sum) << (W - 4));
        carry_d   = add_cout;
        a_sh_d    = a_sh_q >> 4;
        b_sh_d    = b_sh_q >> 4;
        idx_d     = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          res_cout_d = add_cout;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept also covers the DONE retire edge, giving back-to-back operation without an IDLE gap.
    if (accept) begin
      a_sh_d  = op_a;
      b_sh_d  = op_b;
      carry_d = cin;
      idx_d   = 4'd0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      carry_q    <= 1'b0;
      idx_q      <= 4'd0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
    end
  end

endmodule

// File: tb/tb_rca_nibble_seq.sv
// tb/tb_rca_nibble_seq.sv - randomized self-checking bench for rca_nibble_seq (NIBBLES=4 and NIBBLES=1)
module tb_rca_nibble_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          checks = 0;
  int          failures = 0;

  // NIBBLES=4 instance
  logic        start_valid, start_ready, cin, add_cin, add_cout, res_valid, res_ready, res_cout;
  logic [15:0] op_a, op_b, res_sum;
  logic [3:0]  add_a, add_b, add_sum;

  // NIBBLES=1 instance
  logic        n1_start_valid, n1_start_ready, n1_cin, n1_add_cin, n1_add_cout;
  logic        n1_res_valid, n1_res_ready, n1_res_cout;
  logic [3:0]  n1_op_a, n1_op_b, n1_res_sum, n1_add_a, n1_add_b, n1_add_sum;

  // External ripple-carry stages
  assign {add_cout, add_sum}       = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign {n1_add_cout, n1_add_sum} = 5'(n1_add_a) + 5'(n1_add_b) + 5'(n1_add_cin);

  rca_nibble_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout)
  );

  rca_nibble_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .start_valid(n1_start_valid), .start_ready(n1_start_ready),
    .op_a(n1_op_a), .op_b(n1_op_b), .cin(n1_cin),
    .add_a(n1_add_a), .add_b(n1_add_b), .add_cin(n1_add_cin),
    .add_sum(n1_add_sum), .add_cout(n1_add_cout),
    .res_valid(n1_res_valid), .res_ready(n1_res_ready),
    .res_sum(n1_res_sum), .res_cout(n1_res_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation on the 4-nibble instance, starting from IDLE; optional stall with a competing request.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int stall, input logic poke, input string name);
    logic [16:0] exp_full;
    logic [31:0] mask;
    logic [3:0]  exp_a, exp_b;
    logic        exp_c;
    int          lat;
    exp_full = 17'(a) + 17'(b) + 17'(c);
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s start_ready: got %b want 1", name, start_ready);
    end
    op_a = a; op_b = b; cin = c; start_valid = 1'b1; res_ready = 1'b0;
    tick();
    start_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      if (lat < 4) begin
        exp_a = 4'(a >> (4 * lat));
        exp_b = 4'(b >> (4 * lat));
        mask  = (32'd1 << (4 * lat)) - 32'd1;
        exp_c = 1'(((32'(a) & mask) + (32'(b) & mask) + 32'(c)) >> (4 * lat));
        checks++;
        if ({add_a, add_b, add_cin} !== {exp_a, exp_b, exp_c}) begin
          failures++;
          $display("FAIL %s adder_drive nibble%0d: got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                   name, lat, add_a, add_b, add_cin, exp_a, exp_b, exp_c);
        end
      end
      tick();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL %s latency: got %0d edges want 4", name, lat);
    end
    checks++;
    if ({res_valid, res_cout, res_sum} !== {1'b1, exp_full}) begin
      failures++;
      $display("FAIL %s result: got valid=%b cout=%b sum=%h want valid=1 cout=%b sum=%h",
               name, res_valid, res_cout, res_sum, exp_full[16], exp_full[15:0]);
    end
    if (poke) begin
      start_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0000; cin = 1'b0;
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if ({res_valid, res_cout, res_sum, start_ready, add_a, add_b, add_cin} !==
          {1'b1, exp_full, 1'b0, 9'd0}) begin
        failures++;
        $display("FAIL %s stall%0d: got valid=%b cout=%b sum=%h sready=%b add=%h/%h/%b want valid=1 cout=%b sum=%h sready=0 add=0",
                 name, i, res_valid, res_cout, res_sum, start_ready, add_a, add_b, add_cin,
                 exp_full[16], exp_full[15:0]);
      end
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({res_valid, start_ready, add_a, add_b, add_cin} !== {1'b0, 1'b1, 9'd0}) begin
      failures++;
      $display("FAIL %s retire: got valid=%b sready=%b add=%h/%h/%b want valid=0 sready=1 add=0",
               name, res_valid, start_ready, add_a, add_b, add_cin);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b0; res_ready = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    n1_start_valid = 1'b0; n1_res_ready = 1'b0; n1_op_a = '0; n1_op_b = '0; n1_cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({res_valid, res_cout, res_sum, add_a, add_b, add_cin, start_ready} !== {18'd0, 9'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset4: got valid=%b cout=%b sum=%h add=%h/%h/%b sready=%b want all 0 sready=1",
               res_valid, res_cout, res_sum, add_a, add_b, add_cin, start_ready);
    end
    checks++;
    if ({n1_res_valid, n1_res_cout, n1_res_sum, n1_add_a, n1_add_b, n1_add_cin, n1_start_ready} !==
        {6'd0, 9'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset1: got valid=%b cout=%b sum=%h sready=%b want 0/0/0/1",
               n1_res_valid, n1_res_cout, n1_res_sum, n1_start_ready);
    end
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0000, 1'b1, 2, 1'b0, "carry_chain");
  endtask

  task automatic test_stall();
    run_op(16'h8000, 16'h8000, 1'b0, 10, 1'b1, "stall");
  endtask

  task automatic test_back_to_back();
    int lat;
    op_a = 16'h0303; op_b = 16'h0404; cin = 1'b0; start_valid = 1'b1; res_ready = 1'b0;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if ({res_valid, res_cout, res_sum} !== {1'b1, 17'h00707}) begin
      failures++;
      $display("FAIL b2b_first: got valid=%b cout=%b sum=%h want valid=1 cout=0 sum=0707",
               res_valid, res_cout, res_sum);
    end
    res_ready = 1'b1; start_valid = 1'b1; op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_sready: got %b want 1", start_ready);
    end
    tick();
    start_valid = 1'b0; res_ready = 1'b0;
    checks++;
    if ({res_valid, add_a, add_b} !== {1'b0, 4'hF, 4'h1}) begin
      failures++;
      $display("FAIL b2b_no_idle: got valid=%b add_a=%h add_b=%h want valid=0 add_a=f add_b=1",
               res_valid, add_a, add_b);
    end
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4 || {res_cout, res_sum} !== 17'h01010) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d cout=%b sum=%h want lat=4 cout=0 sum=1010",
               lat, res_cout, res_sum);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({res_valid, res_cout, res_sum, add_a, add_b, add_cin, start_ready} !== {18'd0, 9'd0, 1'b1}) begin
      failures++;
      $display("FAIL midrun_reset: got valid=%b cout=%b sum=%h add=%h/%h/%b sready=%b want all 0 sready=1",
               res_valid, res_cout, res_sum, add_a, add_b, add_cin, start_ready);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrun_discard cycle%0d: got valid=%b want 0", i, res_valid);
      end
    end
    res_ready = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0, "max_operands");
    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), "random");
    end
  endtask

  task automatic test_n1();
    logic [3:0] a, b;
    logic       c;
    logic [4:0] exp_full;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        a = 4'h9; b = 4'h8; c = 1'b1;
      end else begin
        a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
      end
      exp_full = 5'(a) + 5'(b) + 5'(c);
      checks++;
      if (n1_start_ready !== 1'b1) begin
        failures++;
        $display("FAIL n1_sready op%0d: got %b want 1", i, n1_start_ready);
      end
      n1_op_a = a; n1_op_b = b; n1_cin = c; n1_start_valid = 1'b1;
      tick();
      n1_start_valid = 1'b0;
      checks++;
      if ({n1_res_valid, n1_start_ready, n1_add_a, n1_add_b, n1_add_cin} !== {2'b00, a, b, c}) begin
        failures++;
        $display("FAIL n1_run op%0d: got valid=%b sready=%b add=%h/%h/%b want 0/0/%h/%h/%b",
                 i, n1_res_valid, n1_start_ready, n1_add_a, n1_add_b, n1_add_cin, a, b, c);
      end
      tick();
      checks++;
      if ({n1_res_valid, n1_res_cout, n1_res_sum} !== {1'b1, exp_full}) begin
        failures++;
        $display("FAIL n1_result op%0d: got valid=%b cout=%b sum=%h want valid=1 cout=%b sum=%h",
                 i, n1_res_valid, n1_res_cout, n1_res_sum, exp_full[4], exp_full[3:0]);
      end
      n1_res_ready = 1'b1;
      tick();
      n1_res_ready = 1'b0;
      checks++;
      if (n1_res_valid !== 1'b0) begin
        failures++;
        $display("FAIL n1_retire op%0d: got valid=%b want 0", i, n1_res_valid);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
